// File: rtl/dpram_port_arbiter_pkg.sv
// Shared definitions for the dual-port RAM port arbiter.
package dpram_port_arbiter_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    // Requester identifiers; the value doubles as the round-robin "last" encoding.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_VID = 1'b1
    } req_id_e;

    // A lock may hold the port for at most LOCK_MAX consecutive grants.
    localparam int LOCK_MAX = 8;
    localparam int LOCK_CW  = 3;
    localparam logic [LOCK_CW-1:0] LOCK_LAST = LOCK_CW'(LOCK_MAX - 1);

endpackage

// File: rtl/dpram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant with per-requester burst lock and a starvation guard.
module rr_arb2
    import dpram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic       gnt_any,
    output req_id_e    gnt_id
);

    req_id_e              last;
    req_id_e              lock_owner;
    logic                 locked;
    logic [LOCK_CW-1:0]   lock_cnt;
    logic [LOCK_CW-1:0]   lock_cnt_nxt;
    logic                 lock_run;
    logic                 lock_sel;

    // Same-cycle grant decision; lock_cnt_nxt is the 0-based index of this grant in a locked run.
    always_comb begin
        gnt_any = !reset && (req[0] || req[1]);
        gnt_id  = REQ_CPU;
        if (req[0] && req[1]) begin
            if (locked)
                gnt_id = lock_owner;
            else
                gnt_id = (last == REQ_CPU) ? REQ_VID : REQ_CPU;
        end else if (req[1]) begin
            gnt_id = REQ_VID;
        end
        lock_run     = locked && (lock_owner == gnt_id);
        lock_cnt_nxt = lock_run ? (lock_cnt + LOCK_CW'(1)) : '0;
        lock_sel     = (gnt_id == REQ_VID) ? lock[1] : lock[0];
    end

    // Round-robin history and lock state; the LOCK_MAX-th grant of a run drops the lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            last       <= REQ_VID;
            locked     <= 1'b0;
            lock_owner <= REQ_CPU;
            lock_cnt   <= '0;
        end else if (gnt_any) begin
            last       <= gnt_id;
            lock_owner <= gnt_id;
            lock_cnt   <= lock_cnt_nxt;
            locked     <= lock_sel && (lock_cnt_nxt != LOCK_LAST);
        end else begin
            locked     <= 1'b0;
            lock_cnt   <= '0;
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one 16-bit block RAM port between the CPU data path and the video/I/O engine.
module dpram_port_arbiter
    import dpram_port_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_q
);

    // The response pipe is a single stage; deeper RAM pipelines are not handled.
    generate
        if (RAM_LAT != 1) begin : g_bad_lat
            $error("dpram_port_arbiter: RAM_LAT must be 1");
        end
    endgenerate

    logic    gnt_any;
    req_id_e gnt_id;
    logic    resp_v;
    req_id_e resp_id;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({r1_req, r0_req}),
        .lock    ({r1_lock, r0_lock}),
        .gnt_any (gnt_any),
        .gnt_id  (gnt_id)
    );

    // Issue mux: idle cycles present a harmless read of address 0.
    always_comb begin
        r0_gnt   = gnt_any && (gnt_id == REQ_CPU);
        r1_gnt   = gnt_any && (gnt_id == REQ_VID);
        mem_en   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (r0_gnt) begin
            mem_en   = r0_we;
            mem_addr = r0_addr;
            mem_data = r0_wdata;
        end else if (r1_gnt) begin
            mem_en   = r1_we;
            mem_addr = r1_addr;
            mem_data = r1_wdata;
        end
    end

    // One-stage response pipe tracking who owns the RAM output next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_v  <= 1'b0;
            resp_id <= REQ_CPU;
        end else begin
            resp_v  <= gnt_any;
            resp_id <= gnt_id;
        end
    end

    // Route RAM output to its owner; reset hides a response already in flight.
    always_comb begin
        r0_rvalid = !reset && resp_v && (resp_id == REQ_CPU);
        r1_rvalid = !reset && resp_v && (resp_id == REQ_VID);
        r0_rdata  = r0_rvalid ? mem_q : '0;
        r1_rdata  = r1_rvalid ? mem_q : '0;
    end

endmodule
